endec_interface: RTL and testbench

ENDEC_INTERFACE -- requirements
Module: endec_interface

---
 rtl/endec_interface.sv | 191 +++++++++++++++++++
 tb/tb_endec_interface.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/endec_interface.sv
// Convolutional encoder and hard-decision Viterbi decoder for one 128-bit frame.
// K=3 or K=9, rate 1/2 or 1/3; configuration is latched on the first enabled cycle.
module endec_interface #(
    parameter int MAX_CONSTRAINT_LENGTH = 9,
    parameter int MAX_CODE_RATE         = 3
) (
    input  logic                                           sys_clk,
    input  logic                                           rst,
    input  logic                                           en,
    input  logic                                           i_code_rate,
    input  logic                                           i_constr_len,
    input  logic [MAX_CODE_RATE*MAX_CONSTRAINT_LENGTH-1:0] i_gen_poly_flat,
    input  logic [127:0]                                   i_encoder_data_frame,
    input  logic [128*MAX_CODE_RATE-1:0]                   i_decoder_data_frame,
    output logic [128*MAX_CODE_RATE-1:0]                   o_encoder_data,
    output logic                                           o_encoder_done,
    output logic [127:0]                                   o_decoder_data,
    output logic                                           o_decoder_done
);
    localparam int FRAME     = 128;
    localparam int MCL       = MAX_CONSTRAINT_LENGTH;
    localparam int CODE_W    = FRAME * MAX_CODE_RATE;
    localparam int MEM       = MCL - 1;
    localparam int NSTATES   = 1 << MEM;
    localparam int K3_STATES = 4;
    localparam int PM_W      = 10;
    localparam int POLY_W    = MAX_CODE_RATE * MCL;

    typedef enum logic [1:0] {DEC_ACS, DEC_SELECT, DEC_IDLE} dec_state_t;
    typedef logic [PM_W:0] sum_t;

    // Accumulated metric of one branch: saturating add of the Hamming distance.
    function automatic logic [PM_W-1:0] path_metric(
        input logic [PM_W-1:0]   pm,
        input logic [MCL-1:0]    win,
        input logic [POLY_W-1:0] polys,
        input logic [2:0]        rx,
        input logic              rate3
    );
        logic [2:0] exp_sym;
        logic [2:0] diff;
        sum_t       sum;
        exp_sym = '0;
        for (int unsigned j = 0; j < 3; j++)
            exp_sym[2-j] = ^(polys[j*MCL +: MCL] & win);
        diff = exp_sym ^ rx;
        if (!rate3)
            diff[0] = 1'b0;
        sum = {1'b0, pm} + sum_t'(diff[2]) + sum_t'(diff[1]) + sum_t'(diff[0]);
        return sum[PM_W] ? '1 : sum[PM_W-1:0];
    endfunction

    logic                 cfg_valid, cfg_rate3, cfg_k9;
    logic [POLY_W-1:0]    cfg_poly;
    logic                 rate3, k9;
    logic [POLY_W-1:0]    polys;

    logic [6:0]           enc_step;
    logic [MEM-1:0]       enc_sr;
    logic [CODE_W-4:0]    enc_buf;
    logic                 enc_bit;
    logic [MCL-1:0]       enc_win;
    logic [2:0]           enc_sym;
    logic [CODE_W-1:0]    enc_next;

    dec_state_t           dec_state;
    logic [6:0]           dec_step;
    logic [PM_W-1:0]      pm        [NSTATES];
    logic [PM_W-1:0]      pm_next   [NSTATES];
    logic [FRAME-1:0]     surv      [NSTATES];
    logic [FRAME-1:0]     surv_next [NSTATES];
    logic [8:0]           base2, base3;
    logic [2:0]           rx;
    logic [MEM-1:0]       p0, p1;
    logic                 b;
    logic [PM_W-1:0]      m0, m1;
    logic [MEM-1:0]       best_idx;
    logic [PM_W-1:0]      best_pm;

    always_comb begin
        rate3 = cfg_valid ? cfg_rate3 : i_code_rate;
        k9    = cfg_valid ? cfg_k9    : i_constr_len;
        polys = (cfg_valid ? cfg_poly : i_gen_poly_flat)
              & (k9 ? {POLY_W{1'b1}} : {MAX_CODE_RATE{9'h007}});
    end

    always_comb begin
        enc_bit = i_encoder_data_frame[7'd127 - enc_step];
        enc_win = {enc_sr, enc_bit};
        enc_sym = '0;
        for (int unsigned j = 0; j < 3; j++)
            enc_sym[2-j] = ^(polys[j*MCL +: MCL] & enc_win);
        enc_next = rate3 ? {enc_buf, enc_sym} : {1'b0, enc_buf, enc_sym[2:1]};
    end

    // State = last K-1 inputs, newest in bit 0; predecessors differ only in the oldest bit.
    always_comb begin
        base2 = 9'd255 - {1'b0, dec_step, 1'b0};
        base3 = 9'd383 - ({2'b0, dec_step} + {1'b0, dec_step, 1'b0});
        rx    = rate3 ? i_decoder_data_frame[base3 -: 3]
                      : {i_decoder_data_frame[base2 -: 2], 1'b0};
        p0 = '0;
        p1 = '0;
        b  = 1'b0;
        m0 = '0;
        m1 = '0;
        for (int unsigned n = 0; n < NSTATES; n++) begin
            p0 = MEM'(n >> 1);
            p1 = p0 | (k9 ? MEM'(1 << (MEM - 1)) : MEM'(2));
            b  = 1'(n);
            m0 = path_metric(pm[p0], {p0, b}, polys, rx, rate3);
            m1 = path_metric(pm[p1], {p1, b}, polys, rx, rate3);
            pm_next[n]   = '1;
            surv_next[n] = '0;
            if (k9 || n < K3_STATES) begin
                if (m0 <= m1) begin
                    pm_next[n]   = m0;
                    surv_next[n] = {surv[p0][FRAME-2:0], b};
                end else begin
                    pm_next[n]   = m1;
                    surv_next[n] = {surv[p1][FRAME-2:0], b};
                end
            end
        end
    end

    always_comb begin
        best_idx = '0;
        best_pm  = pm[0];
        for (int unsigned n = 1; n < NSTATES; n++) begin
            if ((k9 || n < K3_STATES) && pm[n] < best_pm) begin
                best_pm  = pm[n];
                best_idx = MEM'(n);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cfg_valid      <= 1'b0;
            cfg_rate3      <= 1'b0;
            cfg_k9         <= 1'b0;
            cfg_poly       <= '0;
            enc_step       <= '0;
            enc_sr         <= '0;
            enc_buf        <= '0;
            o_encoder_data <= '0;
            o_encoder_done <= 1'b0;
            dec_state      <= DEC_ACS;
            dec_step       <= '0;
            o_decoder_data <= '0;
            o_decoder_done <= 1'b0;
            for (int unsigned n = 0; n < NSTATES; n++) begin
                pm[n]   <= (n == 0) ? '0 : '1;
                surv[n] <= '0;
            end
        end else if (en) begin
            if (!cfg_valid) begin
                cfg_valid <= 1'b1;
                cfg_rate3 <= i_code_rate;
                cfg_k9    <= i_constr_len;
                cfg_poly  <= i_gen_poly_flat;
            end
            if (!o_encoder_done) begin
                enc_sr   <= {enc_sr[MEM-2:0], enc_bit};
                enc_buf  <= enc_next[CODE_W-4:0];
                enc_step <= enc_step + 7'd1;
                if (enc_step == 7'd127) begin
                    o_encoder_data <= enc_next;
                    o_encoder_done <= 1'b1;
                end
            end
            case (dec_state)
                DEC_ACS: begin
                    pm       <= pm_next;
                    surv     <= surv_next;
                    dec_step <= dec_step + 7'd1;
                    if (dec_step == 7'd127)
                        dec_state <= DEC_SELECT;
                end
                DEC_SELECT: begin
                    o_decoder_data <= surv[best_idx];
                    o_decoder_done <= 1'b1;
                    dec_state      <= DEC_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_endec_interface.sv
// Bench for endec_interface: random frames against a time-domain encoder model,
// with decode expectations from encode/decode round trips.
module tb_endec_interface;
    logic         sys_clk = 1'b0;
    logic         rst, en, i_code_rate, i_constr_len;
    logic [26:0]  i_gen_poly_flat;
    logic [127:0] i_encoder_data_frame;
    logic [383:0] i_decoder_data_frame;
    logic [383:0] o_encoder_data;
    logic         o_encoder_done;
    logic [127:0] o_decoder_data;
    logic         o_decoder_done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [26:0] P75   = {9'd0, 9'd5, 9'd7};
    localparam logic [26:0] P753  = {9'd3, 9'd5, 9'd7};
    localparam logic [26:0] PK9R3 = {9'b100100111, 9'b110011011, 9'b111101101};
    localparam logic [26:0] PK9R2 = {9'd0, 9'b111101011, 9'b101110001};

    endec_interface #(.MAX_CONSTRAINT_LENGTH(9), .MAX_CODE_RATE(3)) dut (
        .sys_clk              (sys_clk),
        .rst                  (rst),
        .en                   (en),
        .i_code_rate          (i_code_rate),
        .i_constr_len         (i_constr_len),
        .i_gen_poly_flat      (i_gen_poly_flat),
        .i_encoder_data_frame (i_encoder_data_frame),
        .i_decoder_data_frame (i_decoder_data_frame),
        .o_encoder_data       (o_encoder_data),
        .o_encoder_done       (o_encoder_done),
        .o_decoder_data       (o_decoder_data),
        .o_decoder_done       (o_decoder_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Code bit j at step t = parity of taps over the information sequence u[t-i].
    function automatic logic [383:0] model_encode(input logic [127:0] data, input logic r3,
                                                  input logic k9, input logic [26:0] polys);
        logic [383:0] out;
        int r, taps, n, acc;
        out  = '0;
        r    = r3 ? 3 : 2;
        taps = k9 ? 9 : 3;
        n    = r3 ? 384 : 256;
        for (int t = 0; t < 128; t++)
            for (int j = 0; j < r; j++) begin
                acc = 0;
                for (int i = 0; i < taps; i++)
                    if (t >= i && polys[9*j+i] && data[127-(t-i)]) acc++;
                out[n-1-r*t-j] = acc[0];
            end
        return out;
    endfunction

    task automatic do_frame(input logic r3, input logic k9, input logic [26:0] polys,
                            input logic [127:0] data, input logic flip, input logic chk_dec,
                            input logic scramble, input int pause_at, input int rst_at);
        logic [383:0] exp_enc, code;
        int cyc, enc_cyc, dec_cyc, p, extra;
        bit did_rst;
        exp_enc = model_encode(data, r3, k9, polys);
        code = exp_enc;
        if (!r3) code[383:256] = {$urandom, $urandom, $urandom, $urandom};
        if (flip) begin
            p = r3 ? 383 - int'($urandom_range(0, 179)) : 255 - int'($urandom_range(0, 199));
            code[p] = ~code[p];
        end
        @(negedge sys_clk);
        en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_enc_data", o_encoder_data, '0);
        check("rst_dec_data", {256'd0, o_decoder_data}, '0);
        check("rst_done", {o_encoder_done, o_decoder_done}, 2'b00);
        i_code_rate = r3;
        i_constr_len = k9;
        i_gen_poly_flat = polys;
        i_encoder_data_frame = data;
        i_decoder_data_frame = code;
        @(negedge sys_clk);
        rst = 1'b0;
        en = 1'b1;
        cyc = 0; enc_cyc = -1; dec_cyc = -1; did_rst = 0;
        while ((enc_cyc < 0 || dec_cyc < 0) && cyc < 400) begin
            @(negedge sys_clk);
            cyc++;
            if (o_encoder_done && enc_cyc < 0) enc_cyc = cyc;
            if (o_decoder_done && dec_cyc < 0) dec_cyc = cyc;
            if (cyc == 100) begin
                check("mid_enc_idle", {o_encoder_done, o_encoder_data}, '0);
                check("mid_dec_idle", {o_decoder_done, o_decoder_data}, '0);
            end
            if (scramble && cyc == 3) begin
                i_code_rate = ~r3;
                i_constr_len = ~k9;
                i_gen_poly_flat = 27'($urandom);
            end
            if (!did_rst && rst_at > 0 && cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check("midrst_state", {o_encoder_done, o_decoder_done, o_encoder_data}, '0);
                @(negedge sys_clk);
                rst = 1'b0;
                cyc = 0;
                did_rst = 1;
            end
            en = !(pause_at > 0 && cyc >= pause_at && cyc < pause_at + 10);
        end
        extra = (pause_at > 0) ? 10 : 0;
        check("enc_latency", enc_cyc, 128 + extra);
        check("dec_latency", (dec_cyc >= 129 + extra) && (dec_cyc <= 130 + extra), 1'b1);
        i_encoder_data_frame = ~data;
        i_decoder_data_frame = ~code;
        repeat (5) @(negedge sys_clk);
        check("enc_data", o_encoder_data, exp_enc);
        if (chk_dec) check("dec_data", {256'd0, o_decoder_data}, {256'd0, data});
        check("done_hold", {o_encoder_done, o_decoder_done}, 2'b11);
    endtask

    function automatic logic [26:0] junk_k3(input logic [26:0] base);
        logic [26:0] v;
        v = 27'({$urandom});
        for (int j = 0; j < 3; j++) v[9*j +: 3] = base[9*j +: 3];
        return v;
    endfunction

    initial begin
        logic [383:0] lit;
        logic [127:0] imp;
        rst = 1'b1; en = 1'b0; i_code_rate = 1'b0; i_constr_len = 1'b0;
        i_gen_poly_flat = '0; i_encoder_data_frame = '0; i_decoder_data_frame = '0;
        repeat (2) @(negedge sys_clk);

        do_frame(0, 0, P75, '0, 0, 1, 0, 0, 0);
        imp = 128'h1 << 127;
        do_frame(0, 0, P75, imp, 0, 1, 0, 0, 0);
        lit = '0;
        lit[255:250] = 6'b111011;
        check("k3_impulse_enc", o_encoder_data, lit);
        check("k3_impulse_dec", {256'd0, o_decoder_data}, {256'd0, 128'h8000_0000_0000_0000_0000_0000_0000_0000});

        do_frame(0, 0, junk_k3(P75), {$urandom, $urandom, $urandom, $urandom}, 1, 1, 0, 0, 0);
        do_frame(0, 0, junk_k3(P75), {$urandom, $urandom, $urandom, $urandom}, 1, 1, 0, 60, 0);
        do_frame(0, 0, P75, {$urandom, $urandom, $urandom, $urandom}, 1, 1, 0, 0, 50);

        do_frame(1, 1, PK9R3, imp, 0, 1, 0, 0, 0);
        check("k9_impulse_sym", o_encoder_data[383:381], 3'b111);
        do_frame(1, 1, PK9R3, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 0, 0, 0);
        do_frame(1, 1, PK9R3, {$urandom, $urandom, $urandom, $urandom}, 1, 1, 1, 0, 0);
        do_frame(1, 1, PK9R3, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 0, 40, 0);

        do_frame(1, 0, junk_k3(P753), {$urandom, $urandom, $urandom, $urandom}, 1, 1, 0, 0, 0);
        do_frame(0, 1, PK9R2, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 0, 0, 0);
        do_frame(1, 1, 27'($urandom), {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 0, 0);
        do_frame(0, 0, 27'($urandom), {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
